// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor
//   Sink-side VGA timing checker. It samples HS/VS from the display path and
//   recovers the pixel column and line from them. It measures the line period,
//   the HSYNC width, the frame height and the VSYNC width, and compares each one
//   against the programmed mode. It reports lock once the timing has matched
//   for LOCK_FRAMES consecutive frames.
//
// Ports
//   clk        pixel clock, rising edge
//   rst        asynchronous reset, active low
//   hs, vs     HSYNC / VSYNC from the generator, active low
//   blank_n    generator blank, observed only
//   clr_err    single-cycle pulse clearing err_h / err_v
//   x, y       recovered pixel column / line (registered)
//   de         locked and (x, y) inside the active area
//   locked     timing matched for LOCK_FRAMES frames
//   err_h      sticky horizontal error (line period, HSYNC width, timeout)
//   err_v      sticky vertical error (frame height, VSYNC width)
//   meas_line  last line period in clocks
//   meas_hsw   last HSYNC low width in clocks
//   meas_lines last frame height in lines
//   meas_vsw   last VSYNC low width in lines
module vga_timing_monitor #(
    parameter int H_TOTAL      = 1688,
    parameter int H_ACTIVE     = 1280,
    parameter int H_SYNC_START = 1328,
    parameter int H_SYNC_W     = 112,
    parameter int V_TOTAL      = 1066,
    parameter int V_ACTIVE     = 1024,
    parameter int V_SYNC_START = 1025,
    parameter int V_SYNC_W     = 3,
    parameter int LOCK_FRAMES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hs,
    input  logic        vs,
    input  logic        blank_n,
    input  logic        clr_err,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        de,
    output logic        locked,
    output logic        err_h,
    output logic        err_v,
    output logic [15:0] meas_line,
    output logic [15:0] meas_hsw,
    output logic [11:0] meas_lines,
    output logic [3:0]  meas_vsw
);

    localparam logic [11:0] H_LAST      = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_ACT12     = 12'(H_ACTIVE);
    localparam logic [11:0] H_SS12      = 12'(H_SYNC_START);
    localparam logic [15:0] H_TOTAL16   = 16'(H_TOTAL);
    localparam logic [15:0] H_SW16      = 16'(H_SYNC_W);
    localparam logic [11:0] V_LAST      = 12'(V_TOTAL - 1);
    localparam logic [11:0] V_ACT12     = 12'(V_ACTIVE);
    localparam logic [11:0] V_SS12      = 12'(V_SYNC_START);
    localparam logic [11:0] V_TOTAL12   = 12'(V_TOTAL);
    localparam logic [3:0]  V_SW4       = 4'(V_SYNC_W);
    localparam logic [7:0]  LOCK_N      = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    state_t      state;
    logic        hs_r, hs_rr, vs_r, vs_rr;
    logic        hfall, hrise, vfall, vrise;
    logic [15:0] lcnt, line_len, swc;
    logic [11:0] lines, hcnt, vcnt;
    logic [3:0]  vsc;
    logic [7:0]  good;
    logic        armed;
    logic        timeout, hwrap, checking;
    logic        line_bad, hsw_bad, frame_bad, set_h, set_v;

    // blank_n is carried for observation only; lock never depends on it.
    logic unused_blank;
    assign unused_blank = blank_n;

    // Two-stage input sampling; idle level of both syncs is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_r  <= 1'b1;
            hs_rr <= 1'b1;
            vs_r  <= 1'b1;
            vs_rr <= 1'b1;
        end else begin
            hs_r  <= hs;
            hs_rr <= hs_r;
            vs_r  <= vs;
            vs_rr <= vs_r;
        end
    end

    assign hfall = hs_rr & ~hs_r;
    assign hrise = ~hs_rr & hs_r;
    assign vfall = vs_rr & ~vs_r;
    assign vrise = ~vs_rr & vs_r;

    // Line length including the current clock, saturating.
    assign line_len = (lcnt == 16'hFFFF) ? 16'hFFFF : lcnt + 16'd1;
    // Fires once, on the clock where the line counter reaches saturation.
    assign timeout  = (lcnt == 16'hFFFE) & ~hfall;
    assign hwrap    = ~hfall & (hcnt == H_LAST);

    // Horizontal measurement
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lcnt      <= '0;
            meas_line <= '0;
            swc       <= '0;
            meas_hsw  <= '0;
        end else begin
            if (hfall) begin
                meas_line <= line_len;
                lcnt      <= '0;
            end else begin
                lcnt <= line_len;
            end
            // The falling-edge clock is the first low clock of the pulse.
            if (hfall)
                swc <= 16'd1;
            else if (!hs_r && swc != 16'hFFFF)
                swc <= swc + 16'd1;
            if (hrise)
                meas_hsw <= swc;
        end
    end

    // Vertical measurement
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lines      <= '0;
            meas_lines <= '0;
            vsc        <= '0;
            meas_vsw   <= '0;
        end else begin
            if (vfall) begin
                meas_lines <= lines;
                lines      <= '0;
            end else if (hfall && lines != 12'hFFF) begin
                lines <= lines + 12'd1;
            end
            if (vfall)
                vsc <= {3'b000, hfall};
            else if (hfall && !vs_r && vsc != 4'hF)
                vsc <= vsc + 4'd1;
            if (vrise)
                meas_vsw <= vsc;
        end
    end

    // Coordinate recovery; a VSYNC edge overrides the line increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt <= '0;
            vcnt <= '0;
            x    <= '0;
            y    <= '0;
            de   <= 1'b0;
        end else begin
            if (hfall)
                hcnt <= H_SS12;
            else if (hwrap)
                hcnt <= '0;
            else
                hcnt <= hcnt + 12'd1;

            if (vfall)
                vcnt <= V_SS12;
            else if (hwrap)
                vcnt <= (vcnt == V_LAST) ? 12'd0 : vcnt + 12'd1;

            x  <= hcnt;
            y  <= vcnt;
            // Registered next to locked so that both drop on the same clock.
            de <= (state == LOCKED) & (hcnt < H_ACT12) & (vcnt < V_ACT12);
        end
    end

    // The first line after entering MEASURE is skipped (armed clear) because
    // it may have started before the monitor was watching.
    assign checking  = (state != SEARCH);
    assign line_bad  = checking & armed & hfall & (line_len != H_TOTAL16);
    assign hsw_bad   = checking & armed & hrise & (swc != H_SW16);
    assign frame_bad = checking & vfall & ((lines != V_TOTAL12) | (meas_vsw != V_SW4));
    assign set_h     = timeout | line_bad | hsw_bad;
    assign set_v     = frame_bad;

    // Lock FSM and sticky error flags; a new error beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= SEARCH;
            good   <= '0;
            armed  <= 1'b0;
            locked <= 1'b0;
            err_h  <= 1'b0;
            err_v  <= 1'b0;
        end else begin
            err_h  <= set_h | (err_h & ~clr_err);
            err_v  <= set_v | (err_v & ~clr_err);
            locked <= (state == LOCKED);

            if (set_h || set_v) begin
                state <= SEARCH;
            end else begin
                case (state)
                    SEARCH: begin
                        if (vfall) begin
                            state <= MEASURE;
                            good  <= '0;
                            armed <= 1'b0;
                        end
                    end
                    MEASURE: begin
                        if (hfall)
                            armed <= 1'b1;
                        if (vfall) begin
                            good <= good + 8'd1;
                            if (good + 8'd1 >= LOCK_N)
                                state <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (hfall)
                            armed <= 1'b1;
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Bench for vga_timing_monitor on a reduced 40x12 mode (HS low 28..33,
// VS low on lines 9..10). The bench runs a reference generator. It keeps a
// short history of the generator counters and checks the recovered
// coordinates and de against that history while lock is expected.
`timescale 1ns/1ps
module tb_vga_timing_monitor;

    localparam int HT  = 40;
    localparam int HA  = 24;
    localparam int HSS = 28;
    localparam int HSW = 6;
    localparam int VT  = 12;
    localparam int VA  = 8;
    localparam int VSS = 9;
    localparam int VSW = 2;
    localparam int LF  = 2;

    logic        clk = 1'b0;
    logic        rst, hs, vs, blank_n, clr_err;
    logic [11:0] x, y, meas_lines;
    logic        de, locked, err_h, err_v;
    logic [15:0] meas_line, meas_hsw;
    logic [3:0]  meas_vsw;

    vga_timing_monitor #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_W(HSW),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_W(VSW),
        .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .rst(rst), .hs(hs), .vs(vs), .blank_n(blank_n),
        .clr_err(clr_err), .x(x), .y(y), .de(de), .locked(locked),
        .err_h(err_h), .err_v(err_v), .meas_line(meas_line),
        .meas_hsw(meas_hsw), .meas_lines(meas_lines), .meas_vsw(meas_vsw)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // reference generator state
    int gh = 0, gv = 0;
    int glen = HT, gvt = VT, ghsw = HSW, gvsw = VSW;
    bit gen_run = 0, hs_hold = 0;
    int hx[4], hy[4], hb[4];
    bit chk_track = 0;
    int de_cnt = 0;
    int lock_hits = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        hs      = hs_hold ? 1'b1 : !(gh >= HSS && gh < HSS + ghsw);
        vs      = !(((gv - VSS + gvt) % gvt) < gvsw);
        blank_n = (gh < HA) && (gv < VA);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (gen_run) begin
            gh++;
            if (gh == glen) begin
                gh = 0;
                gv++;
                if (gv == gvt) gv = 0;
            end
        end
        drive();
        for (int i = 3; i > 0; i--) begin
            hx[i] = hx[i-1];
            hy[i] = hy[i-1];
            hb[i] = hb[i-1];
        end
        hx[0] = gh;
        hy[0] = gv;
        hb[0] = int'(blank_n);
    endtask

    // Reset with the generator parked at (0,0); after the k-th tick
    // following release the generator sits at position k.
    task automatic start_gen(input int len, input int nlines, input int vsw_lines);
        rst = 1'b0;
        gen_run = 0;
        hs_hold = 0;
        clr_err = 1'b0;
        glen = len;
        gvt = nlines;
        gvsw = vsw_lines;
        ghsw = HSW;
        gh = 0;
        gv = 0;
        drive();
        repeat (4) tick();
        rst = 1'b1;
        gen_run = 1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_x"}, x, 0);
        check({tag, "_y"}, y, 0);
        check({tag, "_de"}, de, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_err_h"}, err_h, 0);
        check({tag, "_err_v"}, err_v, 0);
        check({tag, "_meas_line"}, meas_line, 0);
        check({tag, "_meas_hsw"}, meas_hsw, 0);
        check({tag, "_meas_lines"}, meas_lines, 0);
        check({tag, "_meas_vsw"}, meas_vsw, 0);
    endtask

    task automatic seek(input int tv, input int th, input string tag);
        int n;
        n = 0;
        while (!(gv == tv && gh == th) && n < 2000) begin
            tick();
            n++;
        end
        check({tag, "_seek_in_budget"}, int'(n < 2000), 1);
    endtask

    // While lock is expected the outputs must equal the generator counters
    // three clocks earlier, and de must follow the generator blank.
    always @(negedge clk) begin
        if (locked) lock_hits++;
        if (chk_track) begin
            check("track_x", x, hx[3]);
            check("track_y", y, hy[3]);
            check("track_de", de, hb[3]);
            check("track_locked", locked, 1);
            check("track_err_h", err_h, 0);
            check("track_err_v", err_v, 0);
            if (de) de_cnt++;
        end
    end

    initial begin
        rst = 1'b0;
        hs = 1'b1;
        vs = 1'b1;
        blank_n = 1'b0;
        clr_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            hx[i] = 0; hy[i] = 0; hb[i] = 0;
        end

        // reset state
        repeat (3) tick();
        check_all_zero("reset");

        // nominal timing: lock after the third VSYNC
        start_gen(HT, VT, VSW);
        repeat (1322) tick();
        check("nom_pre_lock", locked, 0);
        tick();
        check("nom_lock_rise", locked, 1);
        check("nom_x_at_lock", x, 0);
        check("nom_y_at_lock", y, VSS);
        check("nom_meas_line", meas_line, HT);
        check("nom_meas_hsw", meas_hsw, HSW);
        check("nom_meas_lines", meas_lines, VT);
        check("nom_meas_vsw", meas_vsw, VSW);
        check("nom_err_h", err_h, 0);
        check("nom_err_v", err_v, 0);
        de_cnt = 0;
        chk_track = 1;
        repeat (2 * HT * VT) tick();
        chk_track = 0;
        check("nom_de_count", de_cnt, 2 * HA * VA);

        // long lines and one extra line per frame
        start_gen(HT + 1, VT + 1, VSW);
        lock_hits = 0;
        repeat (3 * (HT + 1) * (VT + 1)) tick();
        check("long_meas_line", meas_line, HT + 1);
        check("long_err_h", err_h, 1);
        check("long_err_v", err_v, 0);
        check("long_never_locked", lock_hits, 0);

        // one short HSYNC inside a locked frame
        start_gen(HT, VT, VSW);
        repeat (1323) tick();
        check("hsw_locked", locked, 1);
        seek(3, 0, "hsw");
        ghsw = HSW - 1;
        repeat (HSS) tick();
        repeat (7) tick();
        check("hsw_locked_at_hrise", locked, 1);
        check("hsw_err_h", err_h, 1);
        check("hsw_meas_hsw", meas_hsw, HSW - 1);
        ghsw = HSW;
        tick();
        check("hsw_locked_drop", locked, 0);
        check("hsw_de_drop", de, 0);
        repeat (1166) tick();
        check("hsw_pre_relock", locked, 0);
        tick();
        check("hsw_relock", locked, 1);
        check("hsw_err_h_sticky", err_h, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("hsw_err_h_cleared", err_h, 0);
        de_cnt = 0;
        chk_track = 1;
        repeat (HT * VT) tick();
        chk_track = 0;
        check("hsw_de_count", de_cnt, HA * VA);

        // VSYNC four lines wide
        start_gen(HT, VT, 4);
        repeat (3 * HT * VT) tick();
        check("vsw_meas_vsw", meas_vsw, 4);
        check("vsw_meas_lines", meas_lines, VT);
        check("vsw_err_v", err_v, 1);
        check("vsw_err_h", err_h, 0);
        check("vsw_locked", locked, 0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("vsw_err_v_cleared", err_v, 0);

        // reset pulse mid-line while locked
        start_gen(HT, VT, VSW);
        repeat (1323) tick();
        check("rst_locked_before", locked, 1);
        seek(5, 7, "rst");
        rst = 1'b0;
        #1;
        check_all_zero("rst_async");
        repeat (3) tick();
        check("rst_held_locked", locked, 0);
        check("rst_held_x", x, 0);
        check("rst_held_meas_line", meas_line, 0);
        rst = 1'b1;
        repeat (1112) tick();
        check("rst_pre_relock", locked, 0);
        tick();
        check("rst_relock", locked, 1);
        check("rst_err_h", err_h, 0);
        check("rst_err_v", err_v, 0);

        // HS stuck high: timeout, clear in the same cycle loses
        rst = 1'b0;
        gen_run = 0;
        hs_hold = 1;
        gvsw = 0;
        drive();
        repeat (4) tick();
        rst = 1'b1;
        repeat (65534) tick();
        check("to_before", err_h, 0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("to_err_beats_clr", err_h, 1);
        check("to_locked", locked, 0);
        repeat (70000 - 65535) tick();
        check("to_err_h_held", err_h, 1);
        check("to_meas_line", meas_line, 0);
        check("to_locked_late", locked, 0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("to_err_h_cleared", err_h, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
